regfile_rename: RTL and testbench
=================================

Name: regfile_rename

Overview:
- Architectural register file with per-register rename tags.
- Sits between decode/issue and the ROB commit port.
- Issue reads rs1/rs2 as either a committed value or a pending ROB tag, and claims rd for its ROB entry.
- ROB commit writes the result back and releases the tag when it still owns the register. Branch flush drops all tags.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hard-wired zero).
- ROB_IDX_W, 5, width of a ROB entry tag (ROB_SIZE 32).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  mispredict flush; clear all busy bits.
- rs1_idx  in  5  issue source 1 register index.
- rs1_val  out  XLEN  committed value of rs1 (or forwarded commit value).
- rs1_busy  out  1  rs1 awaits a ROB result.
- rs1_tag  out  ROB_IDX_W  ROB entry producing rs1; valid when rs1_busy.
- rs2_idx  in  5  issue source 2 register index.
- rs2_val  out  XLEN  same as rs1_val, for rs2.
- rs2_busy  out  1  same as rs1_busy, for rs2.
- rs2_tag  out  ROB_IDX_W  same as rs1_tag, for rs2.
- issue_valid  in  1  an instruction is issued this cycle.
- issue_rd  in  5  destination register of the issued instruction.
- issue_has_rd  in  1  instruction writes rd (0 for stores/branches).
- issue_entry  in  ROB_IDX_W  ROB entry assigned to the issued instruction.
- commit_valid  in  1  ROB commit strobe (commit_sgn).
- commit_des  in  5  committed destination register.
- commit_entry  in  ROB_IDX_W  ROB entry being committed.
- commit_result  in  XLEN  committed value.

Behaviour:
- State per register i:
  - val[i] (XLEN)
  - busy[i] (1)
  - tag[i] (ROB_IDX_W)
- Reset (rst=0, async): every val, busy and tag cleared to 0. Read outputs are combinational, so all rs*_val, rs*_busy and rs*_tag read 0 during and after reset until written.
- Read ports are combinational, 0-cycle latency:
  - idx==0: val=0, busy=0, tag=0.
  - Else, if commit_valid && commit_des==idx && busy[idx] && tag[idx]==commit_entry: val=commit_result, busy=0 (commit bypass).
  - Else: val=val[idx], busy=busy[idx], tag=tag[idx].
  - Reads ignore the same-cycle issue rename: "add x1,x1,x2" sees the previous mapping of x1.
- Commit (posedge, rdy=1, commit_valid=1, commit_des!=0):
  - val[des] <= commit_result, unconditionally.
  - busy[des] <= 0 only if tag[des]==commit_entry and no same-cycle rename of des.
  - A stale commit (tag mismatch) updates the value but leaves busy and tag untouched.
- Rename (posedge, rdy=1, issue_valid && issue_has_rd && issue_rd!=0 && !flush): busy[rd] <= 1, tag[rd] <= issue_entry.
- Same-cycle commit and rename of the same register: value from commit; busy=1 and tag=issue_entry from rename. Rename wins.
- Flush (posedge, rdy=1, flush=1):
  - All busy <= 0.
  - Same-cycle issue rename is suppressed.
  - Same-cycle commit value write still occurs.
  - Values are retained.
- rdy=0: no state change. Combinational reads still reflect current state plus commit bypass.
- Writes to x0 (commit or rename) are discarded; x0 never busy.
- Tag equality compares the full ROB_IDX_W bits; wrap-around of ROB indices is handled by the ROB never reusing a live entry.
- Reset asserted mid-operation: immediate clear regardless of clk/rdy; pending commit/issue in that cycle lost.

Decomposition:
- Shared package/defines.v holds:
  - XLEN
  - ROB_IDX_W / ROBENTRY range
  - REG_IDX_W (5)
  - ENTRY_NULL
  - TRUE/FALSE
- One natural sub-module: regfile_read_port (combinational lookup + commit bypass), instantiated twice for rs1 and rs2.

Test Plan:
- Reset then read x5 -> rs1_val=0, rs1_busy=0; rename x5 to entry 3, next cycle read x5 -> busy=1, tag=3.
- x5 tag 3, commit des=5 entry=3 result=0xDEADBEEF -> same-cycle read gives 0xDEADBEEF, busy=0; next cycle val=0xDEADBEEF, busy=0.
- x5 renamed entry 3 then entry 7, commit entry 3 result=0x11 -> val=0x11, busy=1, tag=7; commit entry 7 result=0x22 -> busy=0, val=0x22.
- Same cycle: commit des=6 entry=2 result=0x44 and rename x6 to entry 9 (tag[6] was 2) -> next cycle val=0x44, busy=1, tag=9.
- Rename x1,x2,x3 to entries 1,2,3, then flush with simultaneous rename x4 -> all busy=0, x4 not busy, values unchanged.
- Writes: rename/commit to x0 with result 0x55 -> x0 reads 0, not busy.
- rdy=0: a commit with rdy=0 changes nothing.
- Async reset: rst pulsed low between edges -> all state 0 immediately.

Source files
------------

// File: rtl/regfile_rename_pkg.sv
// Shared types and constants for the renaming register file.
// Width parameters, index/tag types and the commit bundle.
package regfile_rename_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_IDX_W = 5;
    localparam int ROB_SIZE  = 1 << ROB_IDX_W;
    localparam int REG_NUM   = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [XLEN-1:0]      xlen_t;
    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam rob_idx_t ENTRY_NULL = '0;
    localparam logic     TRUE       = 1'b1;
    localparam logic     FALSE      = 1'b0;

    typedef struct packed {
        logic     valid;
        reg_idx_t des;
        rob_idx_t entry;
        xlen_t    result;
    } commit_t;

endpackage

// File: rtl/regfile_rename_if.sv
// Issue/read/commit bundle of the renaming register file.
// master: issue + ROB side driver; slave: the register file.
interface regfile_rename_if;
    import regfile_rename_pkg::*;

    logic     rdy;
    logic     flush;

    reg_idx_t rs1_idx;
    xlen_t    rs1_val;
    logic     rs1_busy;
    rob_idx_t rs1_tag;
    reg_idx_t rs2_idx;
    xlen_t    rs2_val;
    logic     rs2_busy;
    rob_idx_t rs2_tag;

    logic     issue_valid;
    reg_idx_t issue_rd;
    logic     issue_has_rd;
    rob_idx_t issue_entry;

    logic     commit_valid;
    reg_idx_t commit_des;
    rob_idx_t commit_entry;
    xlen_t    commit_result;

    modport master (
        output rdy, flush,
        output rs1_idx, rs2_idx,
        input  rs1_val, rs1_busy, rs1_tag,
        input  rs2_val, rs2_busy, rs2_tag,
        output issue_valid, issue_rd, issue_has_rd, issue_entry,
        output commit_valid, commit_des, commit_entry, commit_result
    );

    modport slave (
        input  rdy, flush,
        input  rs1_idx, rs2_idx,
        output rs1_val, rs1_busy, rs1_tag,
        output rs2_val, rs2_busy, rs2_tag,
        input  issue_valid, issue_rd, issue_has_rd, issue_entry,
        input  commit_valid, commit_des, commit_entry, commit_result
    );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port with same-cycle commit bypass.
// Ports: idx in, register state arrays in, commit in; val/busy/tag out.
module regfile_read_port
    import regfile_rename_pkg::*;
(
    input  reg_idx_t           idx,
    input  xlen_t              val_arr [REG_NUM],
    input  logic [REG_NUM-1:0] busy_vec,
    input  rob_idx_t           tag_arr [REG_NUM],
    input  commit_t            commit,
    output xlen_t              val,
    output logic               busy,
    output rob_idx_t           tag
);

    logic hit;

    // Bypass only when the commit is the producer this register waits on.
    assign hit = commit.valid && (commit.des == idx)
              && busy_vec[idx] && (tag_arr[idx] == commit.entry);

    always_comb begin
        val  = val_arr[idx];
        busy = busy_vec[idx];
        tag  = tag_arr[idx];
        if (idx == '0) begin
            val  = '0;
            busy = FALSE;
            tag  = ENTRY_NULL;
        end else if (hit) begin
            val  = commit.result;
            busy = FALSE;
        end
    end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register ROB rename tags.
// Ports: clk, rst (async active-low), rf (slave bundle: rdy, flush, reads, issue, commit).
module regfile_rename
    import regfile_rename_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    regfile_rename_if.slave rf
);

    xlen_t              val_q [REG_NUM];
    xlen_t              val_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;
    rob_idx_t           tag_q [REG_NUM];
    rob_idx_t           tag_d [REG_NUM];

    commit_t cmt;
    logic    ren;
    logic    cmt_wr;

    assign cmt.valid  = rf.commit_valid;
    assign cmt.des    = rf.commit_des;
    assign cmt.entry  = rf.commit_entry;
    assign cmt.result = rf.commit_result;

    assign ren = rf.issue_valid && rf.issue_has_rd
              && (rf.issue_rd != '0) && !rf.flush;
    assign cmt_wr = rf.commit_valid && (rf.commit_des != '0);

    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rf.rdy) begin
            if (cmt_wr) begin
                val_d[rf.commit_des] = rf.commit_result;
                // A newer rename of the same register keeps it busy.
                if ((tag_q[rf.commit_des] == rf.commit_entry)
                    && !(ren && (rf.issue_rd == rf.commit_des))) begin
                    busy_d[rf.commit_des] = FALSE;
                end
            end
            if (rf.flush) begin
                busy_d = '0;
            end
            if (ren) begin
                busy_d[rf.issue_rd] = TRUE;
                tag_d[rf.issue_rd]  = rf.issue_entry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q  <= '{default: '0};
            busy_q <= '0;
            tag_q  <= '{default: '0};
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    regfile_read_port u_rs1 (
        .idx      (rf.rs1_idx),
        .val_arr  (val_q),
        .busy_vec (busy_q),
        .tag_arr  (tag_q),
        .commit   (cmt),
        .val      (rf.rs1_val),
        .busy     (rf.rs1_busy),
        .tag      (rf.rs1_tag)
    );

    regfile_read_port u_rs2 (
        .idx      (rf.rs2_idx),
        .val_arr  (val_q),
        .busy_vec (busy_q),
        .tag_arr  (tag_q),
        .commit   (cmt),
        .val      (rf.rs2_val),
        .busy     (rf.rs2_busy),
        .tag      (rf.rs2_tag)
    );

endmodule

// File: tb/tb_regfile_rename.sv
// Scoreboard bench for regfile_rename: directed plan plus random traffic.
// Driver queues expected reads from a reference model; monitor compares.
module tb_regfile_rename;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    regfile_rename_if rf ();

    regfile_rename dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf)
    );

    typedef struct {
        bit          rdy;
        bit          flush;
        bit          iv;
        bit          ihr;
        logic [4:0]  ird;
        logic [4:0]  ient;
        bit          cv;
        logic [4:0]  cdes;
        logic [4:0]  cent;
        logic [31:0] cres;
        logic [4:0]  r1;
        logic [4:0]  r2;
    } stim_t;

    typedef struct {
        int unsigned id;
        logic [31:0] v1;
        logic        b1;
        logic [4:0]  t1;
        logic [31:0] v2;
        logic        b2;
        logic [4:0]  t2;
    } exp_t;

    exp_t q[$];

    logic [31:0] mval [32];
    bit          mbusy[32];
    logic [4:0]  mtag [32];

    int n_vec = 0;
    int n_err = 0;
    int unsigned step_id = 0;

    function automatic stim_t idle(input logic [4:0] r1, input logic [4:0] r2);
        stim_t s;
        s.rdy   = 1'b1;
        s.flush = 1'b0;
        s.iv    = 1'b0;
        s.ihr   = 1'b0;
        s.ird   = '0;
        s.ient  = '0;
        s.cv    = 1'b0;
        s.cdes  = '0;
        s.cent  = '0;
        s.cres  = '0;
        s.r1    = r1;
        s.r2    = r2;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        rf.rdy           = s.rdy;
        rf.flush         = s.flush;
        rf.issue_valid   = s.iv;
        rf.issue_has_rd  = s.ihr;
        rf.issue_rd      = s.ird;
        rf.issue_entry   = s.ient;
        rf.commit_valid  = s.cv;
        rf.commit_des    = s.cdes;
        rf.commit_entry  = s.cent;
        rf.commit_result = s.cres;
        rf.rs1_idx       = s.r1;
        rf.rs2_idx       = s.r2;
    endtask

    // Reference read: x0 is zero; a commit hitting the producer a register
    // waits on is seen immediately; otherwise current model contents.
    task automatic model_read(input stim_t s, input logic [4:0] idx,
                              output logic [31:0] v, output logic b,
                              output logic [4:0] t);
        v = mval[idx];
        b = mbusy[idx];
        t = mtag[idx];
        if (idx == 0) begin
            v = 0;
            b = 0;
            t = 0;
        end else if (s.cv && s.cdes == idx && mbusy[idx] && mtag[idx] == s.cent) begin
            v = s.cres;
            b = 0;
        end
    endtask

    task automatic push_exp(input stim_t s);
        exp_t e;
        step_id++;
        e.id = step_id;
        model_read(s, s.r1, e.v1, e.b1, e.t1);
        model_read(s, s.r2, e.v2, e.b2, e.t2);
        q.push_back(e);
    endtask

    task automatic model_clock(input stim_t s);
        bit clr;
        bit ren;
        if (!s.rdy) return;
        ren = s.iv && s.ihr && s.ird != 0 && !s.flush;
        if (s.cv && s.cdes != 0) begin
            clr = (mtag[s.cdes] == s.cent);
            mval[s.cdes] = s.cres;
            if (clr && !(ren && s.ird == s.cdes)) mbusy[s.cdes] = 0;
        end
        if (s.flush) begin
            for (int i = 0; i < 32; i++) mbusy[i] = 0;
        end
        if (ren) begin
            mbusy[s.ird] = 1;
            mtag[s.ird]  = s.ient;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mval[i]  = 0;
            mbusy[i] = 0;
            mtag[i]  = 0;
        end
    endtask

    task automatic cyc(input stim_t s);
        @(posedge clk);
        #1;
        drive(s);
        push_exp(s);
        model_clock(s);
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.rdy   = ($urandom_range(9) != 0);
        s.flush = ($urandom_range(19) == 0);
        s.iv    = $urandom_range(1);
        s.ihr   = ($urandom_range(3) != 0);
        s.ird   = 5'($urandom_range(7));
        s.ient  = 5'($urandom_range(31));
        s.cv    = $urandom_range(1);
        s.cdes  = 5'($urandom_range(7));
        s.cent  = ($urandom_range(9) < 7) ? mtag[s.cdes] : 5'($urandom_range(31));
        s.cres  = $urandom;
        s.r1    = ($urandom_range(1) != 0) ? s.cdes : 5'($urandom_range(7));
        s.r2    = 5'($urandom_range(7));
        return s;
    endfunction

    task automatic chk(input string nm, input int unsigned id,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                chk("rs1_val",  e.id, rf.rs1_val,          e.v1);
                chk("rs1_busy", e.id, 32'(rf.rs1_busy),    32'(e.b1));
                chk("rs1_tag",  e.id, 32'(rf.rs1_tag),     32'(e.t1));
                chk("rs2_val",  e.id, rf.rs2_val,          e.v2);
                chk("rs2_busy", e.id, 32'(rf.rs2_busy),    32'(e.b2));
                chk("rs2_tag",  e.id, 32'(rf.rs2_tag),     32'(e.t2));
            end
        end
    end

    task automatic async_reset_mid_op();
        stim_t s;
        s = rand_stim();
        s.rdy = 1'b1;
        @(posedge clk);
        #1;
        drive(s);
        #2;
        rst = 1'b0;
        model_reset();
        push_exp(s);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(idle(0, 0));
    endtask

    initial begin : stim
        stim_t s;
        model_reset();
        drive(idle(5, 0));
        #3;
        push_exp(idle(5, 0));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;

        cyc(idle(5, 0));
        s = idle(5, 0); s.iv = 1; s.ihr = 1; s.ird = 5; s.ient = 3;
        cyc(s);
        cyc(idle(5, 0));
        s = idle(5, 0); s.cv = 1; s.cdes = 5; s.cent = 3; s.cres = 32'hDEADBEEF;
        cyc(s);
        cyc(idle(5, 0));

        s = idle(5, 0); s.iv = 1; s.ihr = 1; s.ird = 5; s.ient = 3;
        cyc(s);
        s.ient = 7;
        cyc(s);
        s = idle(5, 0); s.cv = 1; s.cdes = 5; s.cent = 3; s.cres = 32'h11;
        cyc(s);
        cyc(idle(5, 0));
        s = idle(5, 0); s.cv = 1; s.cdes = 5; s.cent = 7; s.cres = 32'h22;
        cyc(s);
        cyc(idle(5, 0));

        s = idle(6, 0); s.iv = 1; s.ihr = 1; s.ird = 6; s.ient = 2;
        cyc(s);
        s = idle(6, 0); s.iv = 1; s.ihr = 1; s.ird = 6; s.ient = 9;
        s.cv = 1; s.cdes = 6; s.cent = 2; s.cres = 32'h44;
        cyc(s);
        cyc(idle(6, 5));

        for (int i = 1; i <= 3; i++) begin
            s = idle(5'(i), 4); s.iv = 1; s.ihr = 1;
            s.ird = 5'(i); s.ient = 5'(i);
            cyc(s);
        end
        s = idle(1, 2); s.flush = 1; s.iv = 1; s.ihr = 1; s.ird = 4; s.ient = 4;
        cyc(s);
        cyc(idle(3, 4));
        cyc(idle(1, 2));

        s = idle(0, 0); s.iv = 1; s.ihr = 1; s.ird = 0; s.ient = 8;
        s.cv = 1; s.cdes = 0; s.cent = 8; s.cres = 32'h55;
        cyc(s);
        cyc(idle(0, 0));

        s = idle(7, 0); s.iv = 1; s.ihr = 1; s.ird = 7; s.ient = 5;
        cyc(s);
        s = idle(7, 0); s.rdy = 0; s.cv = 1; s.cdes = 7; s.cent = 5; s.cres = 32'h77;
        cyc(s);
        cyc(idle(7, 0));

        for (int i = 0; i < 300; i++) cyc(rand_stim());

        async_reset_mid_op();
        cyc(idle(5, 6));
        cyc(idle(7, 1));

        for (int i = 0; i < 300; i++) cyc(rand_stim());

        cyc(idle(0, 0));
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
